// File: rtl/fault_mem_model_if.sv
// Bus between the MBIST controller (master) and the faulty memory model
// (slave): access strobe, read return and fault-configuration fields.
interface fault_mem_model_if #(
  parameter int AWIDTH = 4,
  parameter int DWIDTH = 8
);
  localparam int BW = $clog2(DWIDTH);

  // access channel
  logic              en;
  logic              we;
  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] wdata;
  logic [DWIDTH-1:0] rdata;
  logic              rvalid;

  // fault configuration channel
  logic              cfg_load;
  logic [1:0]        fault;
  logic [AWIDTH-1:0] fault_addr;
  logic [BW-1:0]     fault_bit;
  logic              fault_val;
  logic [AWIDTH-1:0] aggr_addr;
  logic              fault_hit;

  modport master (
    output en, we, addr, wdata,
    output cfg_load, fault, fault_addr, fault_bit, fault_val, aggr_addr,
    input  rdata, rvalid, fault_hit
  );

  modport slave (
    input  en, we, addr, wdata,
    input  cfg_load, fault, fault_addr, fault_bit, fault_val, aggr_addr,
    output rdata, rvalid, fault_hit
  );
endinterface

// File: rtl/fault_mem_model.sv
// Single-port RAM with one injectable fault (stuck-at, transition or
// coupling), used as the target of an MBIST controller. Read latency 1.
module fault_mem_model #(
  parameter int AWIDTH = 4,
  parameter int DWIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  fault_mem_model_if.slave bus
);
  localparam int DEPTH = 2**AWIDTH;
  localparam int BW    = $clog2(DWIDTH);

  typedef enum logic [1:0] {
    F_STUCK  = 2'b00,
    F_TRANS  = 2'b01,
    F_COUPLE = 2'b10,
    F_NONE   = 2'b11
  } fault_e;

  // storage and registered outputs
  logic [DEPTH-1:0][DWIDTH-1:0] mem_q;
  logic [DWIDTH-1:0]            rdata_q;
  logic                         rvalid_q;
  logic                         hit_q;

  // latched fault configuration
  fault_e                       cfg_type_q;
  logic [AWIDTH-1:0]            cfg_addr_q;
  logic [BW-1:0]                cfg_bit_q;
  logic                         cfg_val_q;
  logic [AWIDTH-1:0]            cfg_aggr_q;

  // per-access next-state values
  logic [DWIDTH-1:0]            old_word;
  logic [DWIDTH-1:0]            wr_word_d;
  logic [DWIDTH-1:0]            rd_word_d;
  logic                         at_victim;
  logic                         at_aggr;
  logic                         old_bit;
  logic                         new_bit;
  logic                         wr_acc;
  logic                         rd_acc;
  logic                         flip_d;
  logic                         hit_d;

  assign wr_acc    = bus.en &  bus.we;
  assign rd_acc    = bus.en & ~bus.we;
  assign old_word  = mem_q[bus.addr];
  assign at_victim = (bus.addr == cfg_addr_q);
  // self-coupling is defined as fault-free, so the aggressor never matches
  // when it aliases the victim
  assign at_aggr   = (bus.addr == cfg_aggr_q) && (cfg_aggr_q != cfg_addr_q);
  assign old_bit   = old_word[cfg_bit_q];
  assign new_bit   = bus.wdata[cfg_bit_q];

  // Apply the active fault to the word being written/read and flag activation.
  // The configuration used here is the registered one, so a cfg_load in the
  // same cycle as an access does not affect that access.
  always_comb begin
    wr_word_d = bus.wdata;
    rd_word_d = old_word;
    flip_d    = 1'b0;
    hit_d     = 1'b0;
    case (cfg_type_q)
      F_STUCK: begin
        if (at_victim) begin
          wr_word_d[cfg_bit_q] = cfg_val_q;
          rd_word_d[cfg_bit_q] = cfg_val_q;
          hit_d                = bus.en;
        end
      end
      F_TRANS: begin
        // only a rising transition on the victim bit is blocked
        if (wr_acc && at_victim && !old_bit && new_bit) begin
          wr_word_d[cfg_bit_q] = 1'b0;
          hit_d                = 1'b1;
        end
      end
      F_COUPLE: begin
        // aggressor bit rising 0->1 toggles the same bit of the victim word
        if (wr_acc && at_aggr && !old_bit && new_bit) begin
          flip_d = 1'b1;
          hit_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Memory array: normal write plus coupling inversion of the victim word.
  // Aggressor and victim never alias, so the two updates cannot collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr_acc) mem_q[bus.addr] <= wr_word_d;
      if (flip_d) mem_q[cfg_addr_q][cfg_bit_q] <= ~mem_q[cfg_addr_q][cfg_bit_q];
    end
  end

  // Read data register holds between reads; rvalid/fault_hit are 1-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      if (rd_acc) rdata_q <= rd_word_d;
      rvalid_q <= rd_acc;
      hit_q    <= hit_d;
    end
  end

  // Fault configuration register; reset leaves the memory fault-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_type_q <= F_NONE;
      cfg_addr_q <= '0;
      cfg_bit_q  <= '0;
      cfg_val_q  <= 1'b0;
      cfg_aggr_q <= '0;
    end else if (bus.cfg_load) begin
      cfg_type_q <= fault_e'(bus.fault);
      cfg_addr_q <= bus.fault_addr;
      cfg_bit_q  <= bus.fault_bit;
      cfg_val_q  <= bus.fault_val;
      cfg_aggr_q <= bus.aggr_addr;
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.fault_hit = hit_q;

endmodule

// File: tb/tb_fault_mem_model.sv
// Directed bench for fault_mem_model: fault-free access, each fault type,
// configuration timing and reset during a pending read.
module tb_fault_mem_model;
  localparam int AW = 4;
  localparam int DW = 8;

  logic clk;
  logic rst;
  int   n_tot;
  int   n_bad;

  fault_mem_model_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  fault_mem_model #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // outputs are sampled 1 time unit after the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.en = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    tick();
    bus.en = 1'b0; bus.we = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    bus.en = 1'b1; bus.we = 1'b0; bus.addr = a;
    tick();
    bus.en = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] f, input logic [AW-1:0] fa,
                         input logic [2:0] fb, input logic fv, input logic [AW-1:0] aa);
    bus.fault = f; bus.fault_addr = fa; bus.fault_bit = fb;
    bus.fault_val = fv; bus.aggr_addr = aa;
  endtask

  task automatic cfg(input logic [1:0] f, input logic [AW-1:0] fa,
                     input logic [2:0] fb, input logic fv, input logic [AW-1:0] aa);
    set_cfg(f, fa, fb, fv, aa);
    bus.cfg_load = 1'b1;
    tick();
    bus.cfg_load = 1'b0;
  endtask

  initial begin
    n_tot = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.en = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus.cfg_load = 1'b0;
    set_cfg(2'b11, '0, '0, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata",  bus.rdata,     8'h00);
    chk("rst_rvalid", bus.rvalid,    1'b0);
    chk("rst_hit",    bus.fault_hit, 1'b0);
    rst = 1'b0;

    // fault-free write/read, latency and hold
    wr(4'd3, 8'hA5);
    chk("nf_wr_rvalid", bus.rvalid,    1'b0);
    chk("nf_wr_hit",    bus.fault_hit, 1'b0);
    rd(4'd3);
    chk("nf_rd_rvalid", bus.rvalid,    1'b1);
    chk("nf_rd_data",   bus.rdata,     8'hA5);
    chk("nf_rd_hit",    bus.fault_hit, 1'b0);
    // en=0 with a write pattern on the bus must be ignored
    bus.we = 1'b1; bus.addr = 4'd3; bus.wdata = 8'h00;
    tick();
    bus.we = 1'b0;
    chk("nf_idle_rvalid", bus.rvalid, 1'b0);
    chk("nf_idle_hold",   bus.rdata,  8'hA5);
    rd(4'd3);
    chk("nf_en0_ignored", bus.rdata,  8'hA5);

    // stuck-at 0 on bit 0 of word 3
    cfg(2'b00, 4'd3, 3'd0, 1'b0, 4'd0);
    wr(4'd3, 8'hFF);
    chk("sa_wr_hit", bus.fault_hit, 1'b1);
    tick();
    chk("sa_hit_pulse", bus.fault_hit, 1'b0);
    rd(4'd3);
    chk("sa_rd_data", bus.rdata,     8'hFE);
    chk("sa_rd_hit",  bus.fault_hit, 1'b1);
    rd(4'd4);
    chk("sa_other_data", bus.rdata,     8'h00);
    chk("sa_other_hit",  bus.fault_hit, 1'b0);
    // stuck-at override on read applies even though stored bit differs
    cfg(2'b11, 4'd0, 3'd0, 1'b0, 4'd0);
    wr(4'd3, 8'h01);
    cfg(2'b00, 4'd3, 3'd0, 1'b0, 4'd0);
    rd(4'd3);
    chk("sa_override", bus.rdata, 8'h00);

    // transition fault on bit 7 of word 5
    cfg(2'b01, 4'd5, 3'd7, 1'b0, 4'd0);
    wr(4'd5, 8'h00);
    chk("tr_w00_hit", bus.fault_hit, 1'b0);
    wr(4'd5, 8'h80);
    chk("tr_w80_hit", bus.fault_hit, 1'b1);
    rd(4'd5);
    chk("tr_rd0", bus.rdata, 8'h00);
    chk("tr_rd_hit", bus.fault_hit, 1'b0);
    cfg(2'b11, 4'd0, 3'd0, 1'b0, 4'd0);
    wr(4'd5, 8'h80);
    cfg(2'b01, 4'd5, 3'd7, 1'b0, 4'd0);
    rd(4'd5);
    chk("tr_preload", bus.rdata, 8'h80);
    wr(4'd5, 8'h00);
    chk("tr_fall_hit", bus.fault_hit, 1'b0);
    rd(4'd5);
    chk("tr_rd1", bus.rdata, 8'h00);

    // coupling: aggressor word 2, victim word 9, bit 1
    cfg(2'b10, 4'd9, 3'd1, 1'b0, 4'd2);
    wr(4'd2, 8'h02);
    chk("cp_wr_hit", bus.fault_hit, 1'b1);
    rd(4'd9);
    chk("cp_victim", bus.rdata, 8'h02);
    rd(4'd2);
    chk("cp_aggr", bus.rdata, 8'h02);
    wr(4'd2, 8'h02);
    chk("cp_rewr_hit", bus.fault_hit, 1'b0);
    rd(4'd9);
    chk("cp_victim_keep", bus.rdata, 8'h02);
    // self-coupling is fault-free
    cfg(2'b10, 4'd10, 3'd1, 1'b0, 4'd10);
    wr(4'd10, 8'h02);
    chk("cp_self_hit", bus.fault_hit, 1'b0);
    rd(4'd10);
    chk("cp_self_data", bus.rdata, 8'h02);

    // config load in the same cycle as a write: old config (none) applies
    cfg(2'b11, 4'd0, 3'd0, 1'b0, 4'd0);
    set_cfg(2'b00, 4'd6, 3'd0, 1'b0, 4'd0);
    bus.cfg_load = 1'b1;
    bus.en = 1'b1; bus.we = 1'b1; bus.addr = 4'd6; bus.wdata = 8'h01;
    tick();
    bus.cfg_load = 1'b0; bus.en = 1'b0; bus.we = 1'b0;
    chk("ct_same_hit", bus.fault_hit, 1'b0);
    cfg(2'b11, 4'd0, 3'd0, 1'b0, 4'd0);
    rd(4'd6);
    chk("ct_stored", bus.rdata, 8'h01);
    cfg(2'b00, 4'd6, 3'd0, 1'b0, 4'd0);
    wr(4'd6, 8'h01);
    chk("ct_next_hit", bus.fault_hit, 1'b1);
    cfg(2'b11, 4'd0, 3'd0, 1'b0, 4'd0);
    rd(4'd6);
    chk("ct_next_stored", bus.rdata, 8'h00);

    // reset while a read result is pending
    wr(4'd4, 8'h5A);
    cfg(2'b00, 4'd4, 3'd2, 1'b1, 4'd0);
    rd(4'd4);
    chk("rr_pre_data",  bus.rdata,     8'h5E);
    chk("rr_pre_valid", bus.rvalid,    1'b1);
    chk("rr_pre_hit",   bus.fault_hit, 1'b1);
    rst = 1'b1;
    #1;
    chk("rr_async_valid", bus.rvalid,    1'b0);
    chk("rr_async_data",  bus.rdata,     8'h00);
    chk("rr_async_hit",   bus.fault_hit, 1'b0);
    tick();
    rst = 1'b0;
    rd(4'd4);
    chk("rr_post_data",  bus.rdata,     8'h00);
    chk("rr_post_valid", bus.rvalid,    1'b1);
    chk("rr_post_hit",   bus.fault_hit, 1'b0);
    rd(4'd3);
    chk("rr_post_a3", bus.rdata, 8'h00);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/fault_mem_model.md
FAULT_MEM_MODEL -- requirements
Module: fault_mem_model

Interface
REQ-001 SHALL have parameter AWIDTH, default 4, address width; depth = 2**AWIDTH words.
REQ-002 SHALL have parameter DWIDTH, default 8, word width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  access strobe; one access per cycle when high.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read; sampled only when en=1.
REQ-007 SHALL have port addr  input  AWIDTH  word address.
REQ-008 SHALL have port wdata  input  DWIDTH  write data.
REQ-009 SHALL have port rdata  output  DWIDTH  registered read data.
REQ-010 SHALL have port rvalid  output  1  one-cycle pulse marking rdata valid.
REQ-011 SHALL have port cfg_load  input  1  latch fault configuration inputs.
REQ-012 SHALL have port fault  input  2  fault type: 00 stuck-at, 01 transition, 10 coupling, 11 none.
REQ-013 SHALL have port fault_addr  input  AWIDTH  victim word address.
REQ-014 SHALL have port fault_bit  input  $clog2(DWIDTH)  victim/aggressor bit index.
REQ-015 SHALL have port fault_val  input  1  stuck-at value.
REQ-016 SHALL have port aggr_addr  input  AWIDTH  coupling aggressor word address.
REQ-017 SHALL have port fault_hit  output  1  one-cycle pulse when an access activates the configured fault.

Function
REQ-018 SHALL be a single-port RAM responder to the MBIST controller: 2**AWIDTH x DWIDTH array plus registered fault configuration.
REQ-019 SHALL latch fault, fault_addr, fault_bit, fault_val, aggr_addr on a cycle with cfg_load=1; new configuration governs accesses from the next cycle onward.
REQ-020 SHALL, for cfg_load and en in the same cycle, apply the previous configuration to that access.
REQ-021 SHALL write wdata to mem[addr] on en=1, we=1, modified only by the active fault rules below.
REQ-022 SHALL, on en=1, we=0, load rdata with mem[addr] (fault-modified) and assert rvalid the following cycle; read latency exactly 1 cycle.
REQ-023 SHALL hold rdata unchanged between reads; rvalid low in every cycle not following a read.
REQ-024 Stuck-at (00): bit fault_bit of word fault_addr SHALL read as fault_val and SHALL be stored as fault_val on every write; other bits unaffected.
REQ-025 Transition (01): a write to fault_addr attempting 0->1 on fault_bit SHALL leave the bit 0; 1->0 and same-value writes SHALL succeed.
REQ-026 Coupling (10): a write to aggr_addr that changes its fault_bit from 0 to 1 SHALL invert bit fault_bit of word fault_addr in the same edge.
REQ-027 Coupling with aggr_addr = fault_addr SHALL behave as fault-free (no self-coupling).
REQ-028 None (11): memory SHALL behave ideally.
REQ-029 SHALL pulse fault_hit for one cycle after: a read or write of fault_addr under stuck-at; a suppressed 0->1 write under transition; a victim inversion under coupling.
REQ-030 SHALL NOT rewrite stored contents when the fault type changes; stuck-at override applies on read regardless of stored bit.
REQ-031 SHALL ignore we, addr, wdata when en=0.

Reset
REQ-032 SHALL, while rst=1, clear all memory words to 0, rdata=0, rvalid=0, fault_hit=0, fault config to 11 (none) with all other config fields 0.
REQ-033 SHALL, on rst asserted mid-operation, abort any pending rvalid/fault_hit immediately; first access allowed on first rising edge with rst=0.

Verification
REQ-034 No fault: write 0xA5 to addr 3, read addr 3 -> rdata=0xA5, rvalid high exactly 1 cycle after read strobe, fault_hit stays 0.
REQ-035 Stuck-at: cfg fault=00, fault_addr=3, fault_bit=0, fault_val=0; write 0xFF to 3, read -> rdata=0xFE, fault_hit pulses on write and read.
REQ-036 Transition: cfg fault=01, fault_addr=5, fault_bit=7; write 0x00 then 0x80 to 5, read -> 0x00; write 0x80 with bit preloaded 1 then 0x00, read -> 0x00.
REQ-037 Coupling: cfg fault=10, aggr_addr=2, fault_addr=9, fault_bit=1; mem[9]=0x00, write 0x02 to 2 -> read 9 returns 0x02; rewrite 0x02 to 2 -> 9 unchanged.
REQ-038 Config timing: cfg_load with same-cycle write under old config none, new stuck-at -> that write stored unmodified; next write faulted.
REQ-039 Reset mid-read: assert rst the cycle after read strobe -> rvalid=0, rdata=0 immediately; subsequent read of any address -> 0x00, fault type none.
